icache_refill: RTL and testbench

//   Memory-side responder for the fetch stage's instruction cache. Owns the
//   32-word instruction memory. On a cache miss it captures the missing line
//   tag, waits a fixed memory latency, and reads the line's 4 words in a
//   one-word-per-cycle burst. It then returns the assembled 128-bit line with
//   a 9-bit tag on a single-cycle write strobe, and counts completed refills.

---
 rtl/icache_refill.sv | 110 +++++++++++
 tb/tb_icache_refill.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/icache_refill.sv
// Instruction-cache refill engine: owns the instruction memory and
// returns a full 4-word line plus tag after a fixed memory latency.
module icache_refill #(
  parameter int MEM_LATENCY = 4,
  parameter int IMEM_DEPTH  = 32,
  parameter int WORD_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  miss_req,
  input  logic [5:0]            miss_addr,
  input  logic                  imem_we,
  input  logic [4:0]            imem_waddr,
  input  logic [WORD_W-1:0]     imem_wdata,
  output logic                  wr_icache,
  output logic [4*WORD_W-1:0]   wr_line,
  output logic [8:0]            wr_tag,
  output logic                  busy,
  output logic [7:0]            refill_count
);

  typedef enum logic [2:0] {
    IDLE, WAIT, BURST, FILL, COOL
  } state_t;

  localparam logic [3:0] LAT_LAST = 4'(MEM_LATENCY - 1);

  state_t state, nextState;

  logic [WORD_W-1:0] imem [IMEM_DEPTH];
  logic [WORD_W-1:0] lineBuf [3];
  logic [WORD_W-1:0] rdWord;
  logic [2:0]        tag;
  logic [3:0]        latCnt;
  logic [1:0]        beat;
  logic              accept;
  logic              unusedAddrBits;

  assign unusedAddrBits = ^{miss_addr[5], miss_addr[1:0]};

  // COOL also accepts so a held miss repeats every MEM_LATENCY+6 cycles
  assign accept = miss_req && (state == IDLE || state == COOL);
  assign rdWord = imem[{tag, beat}];

  // loader write port; contents survive reset
  always_ff @(posedge clk) begin
    if (imem_we)
      imem[imem_waddr] <= imem_wdata;
  end

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= nextState;
  end

  // next-state logic
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:  if (miss_req) nextState = WAIT;
      WAIT:  if (latCnt == LAT_LAST) nextState = BURST;
      BURST: if (beat == 2'd3) nextState = FILL;
      FILL:  nextState = COOL;
      COOL:  nextState = miss_req ? WAIT : IDLE;
      default: nextState = IDLE;
    endcase
  end

  // registered outputs and refill datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag          <= '0;
      latCnt       <= '0;
      beat         <= '0;
      lineBuf[0]   <= '0;
      lineBuf[1]   <= '0;
      lineBuf[2]   <= '0;
      wr_icache    <= 1'b0;
      wr_line      <= '0;
      wr_tag       <= '0;
      busy         <= 1'b0;
      refill_count <= '0;
    end else begin
      wr_icache <= (nextState == FILL);
      busy      <= (nextState != IDLE);
      if (accept) begin
        tag    <= miss_addr[4:2];
        latCnt <= '0;
      end else if (state == WAIT) begin
        latCnt <= latCnt + 4'd1;
      end
      if (state == WAIT)
        beat <= '0;
      else if (state == BURST)
        beat <= beat + 2'd1;
      if (state == BURST && beat != 2'd3)
        lineBuf[beat] <= rdWord;
      if (state == BURST && beat == 2'd3) begin
        wr_line <= {rdWord, lineBuf[2], lineBuf[1], lineBuf[0]};
        wr_tag  <= {1'b1, 3'b000, tag, 2'b01};
        if (refill_count != 8'hFF)
          refill_count <= refill_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_icache_refill.sv
// Scoreboard bench for icache_refill: random and directed refills
// checked against a line/tag/count/timing reference model.
module tb_icache_refill;

  localparam int LAT = 4;
  localparam int P   = 10;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         miss_req = 1'b0;
  logic [5:0]   miss_addr = '0;
  logic         imem_we = 1'b0;
  logic [4:0]   imem_waddr = '0;
  logic [31:0]  imem_wdata = '0;
  logic         wr_icache;
  logic [127:0] wr_line;
  logic [8:0]   wr_tag;
  logic         busy;
  logic [7:0]   refill_count;

  icache_refill #(.MEM_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .miss_req(miss_req), .miss_addr(miss_addr),
    .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata),
    .wr_icache(wr_icache), .wr_line(wr_line),
    .wr_tag(wr_tag), .busy(busy),
    .refill_count(refill_count)
  );

  always #(P/2) clk = ~clk;

  typedef struct {
    logic [127:0] line;
    logic [8:0]   tag;
    logic [7:0]   cnt;
    time          t;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  logic [31:0] mdl [32];
  int          mdlCnt = 0;
  int          errs = 0;
  int          checks = 0;
  time         acceptT;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic bound_fail(input string nm);
    checks++;
    errs++;
    $display("FAIL %s: bound expired", nm);
  endtask

  function automatic logic [127:0] lineOf(input logic [2:0] t);
    logic [127:0] r;
    for (int k = 0; k < 4; k++)
      r[32*k +: 32] = mdl[int'(t) * 4 + k];
    return r;
  endfunction

  function automatic exp_t mkExp(input logic [5:0] a, input time t0);
    exp_t e;
    mdlCnt   = (mdlCnt < 255) ? mdlCnt + 1 : 255;
    e.line   = lineOf(a[4:2]);
    e.tag    = {1'b1, 3'b000, a[4:2], 2'b01};
    e.cnt    = 8'(mdlCnt);
    e.t      = t0 + (LAT + 4) * P + P / 2;
    return e;
  endfunction

  // monitor: every strobe must match the oldest expected refill
  always @(negedge clk) begin
    if (wr_icache) begin
      if (sb.size() == 0) begin
        bound_fail("unexpected_strobe");
      end else begin
        cur = sb.pop_front();
        chk("line", wr_line, cur.line);
        chk("tag", 128'(wr_tag), 128'(cur.tag));
        chk("count", 128'(refill_count), 128'(cur.cnt));
        chk("strobe_time", 128'($time), 128'(cur.t));
      end
    end
  end

  task automatic memWrite(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    imem_we = 1'b1;
    imem_waddr = a;
    imem_wdata = d;
    @(posedge clk);
    #1 imem_we = 1'b0;
    mdl[a] = d;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) bound_fail("drain");
  endtask

  task automatic doMiss(input logic [5:0] a,
                        input bit push,
                        input bit hold);
    int n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) bound_fail("idle_wait");
    miss_req = 1'b1;
    miss_addr = a;
    @(posedge clk);
    acceptT = $time;
    if (push) sb.push_back(mkExp(a, acceptT));
    if (!hold) #1 miss_req = 1'b0;
  endtask

  initial begin
    bit busyOk;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_strobe", 128'(wr_icache), 128'(0));
    chk("rst_line", wr_line, 128'(0));
    chk("rst_tag", 128'(wr_tag), 128'(0));
    chk("rst_count", 128'(refill_count), 128'(0));
    @(negedge clk) reset = 1'b0;

    for (int i = 0; i < 32; i++)
      memWrite(5'(i), 32'(i));

    doMiss(6'd5, 1, 0);
    drain();
    doMiss(6'd31, 1, 0);
    drain();

    doMiss(6'd8, 1, 0);
    miss_addr = 6'd20;
    busyOk = 1'b1;
    for (int k = 0; k <= LAT + 5; k++) begin
      @(negedge clk);
      if (!busy) busyOk = 1'b0;
    end
    chk("busy_hold", 128'(busyOk), 128'(1));
    drain();

    doMiss(6'd8, 1, 0);
    repeat (LAT + 1) @(posedge clk);
    #1;
    imem_we = 1'b1;
    imem_waddr = 5'd9;
    imem_wdata = 32'hDEAD;
    @(posedge clk);
    #1 imem_we = 1'b0;
    mdl[9] = 32'hDEAD;
    drain();
    doMiss(6'd10, 1, 0);
    drain();

    doMiss(6'd44, 0, 0);
    repeat (LAT + 2) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("midrst_busy", 128'(busy), 128'(0));
    chk("midrst_count", 128'(refill_count), 128'(0));
    chk("midrst_strobe", 128'(wr_icache), 128'(0));
    mdlCnt = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    repeat (LAT + 8) @(posedge clk);
    doMiss(6'($urandom), 1, 0);
    drain();

    for (int it = 0; it < 40; it++) begin
      drain();
      repeat ($urandom_range(0, 3))
        memWrite(5'($urandom), $urandom);
      doMiss(6'($urandom), 1, 0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    drain();

    doMiss(6'd22, 1, 1);
    for (int k = 1; k < 300; k++) begin
      exp_t e;
      e = mkExp(6'd22, acceptT + k * (LAT + 6) * P);
      sb.push_back(e);
    end
    repeat (299 * (LAT + 6)) @(posedge clk);
    #1 miss_req = 1'b0;
    drain();
    repeat (LAT + 8) @(posedge clk);
    #1;
    chk("sat_count", 128'(refill_count), 128'(8'hFF));
    chk("queue_empty", 128'(sb.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
